// File: rtl/multicycle_controller.sv
// Multicycle control unit for the 32-bit ARM-subset processor.
// Sequences each instruction through its states, drives datapath strobes and selects, and holds NZCV.
module multicycle_controller (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] instr,
    input  logic [3:0]  alu_flags,
    output logic        pc_write,
    output logic        ir_write,
    output logic        mem_write,
    output logic        reg_write,
    output logic        adr_src,
    output logic        alu_src_a,
    output logic [1:0]  alu_src_b,
    output logic [1:0]  result_src,
    output logic [1:0]  alu_control,
    output logic [1:0]  imm_src,
    output logic [3:0]  flags
);

    // state  | meaning
    // FETCH  | read instruction at PC, load IR, PC <= PC+4
    // DECODE | read registers, form PC+8, latch condition result
    // MEMADR | compute load/store address
    // MEMRD  | read data memory at computed address
    // MEMWB  | write loaded data to rd (or PC when rd=15)
    // MEMWR  | write data memory
    // EXECR  | data-processing with register operand
    // EXECI  | data-processing with immediate operand
    // ALUWB  | write ALU result to rd (or PC when rd=15)
    // BRANCH | PC <= PC+8+offset when condition holds
    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,
        S_DECODE = 4'd1,
        S_MEMADR = 4'd2,
        S_MEMRD  = 4'd3,
        S_MEMWB  = 4'd4,
        S_MEMWR  = 4'd5,
        S_EXECR  = 4'd6,
        S_EXECI  = 4'd7,
        S_ALUWB  = 4'd8,
        S_BRANCH = 4'd9
    } state_t;

    state_t state, state_next;
    logic   cond_ex, cond_ex_q;

    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] rd;
    logic       unused_bits;

    assign cond        = instr[31:28];
    assign op          = instr[27:26];
    assign funct       = instr[25:20];
    assign rd          = instr[15:12];
    assign unused_bits = ^{instr[19:16], instr[11:0]};

    logic flag_n, flag_z, flag_c, flag_v;
    assign {flag_n, flag_z, flag_c, flag_v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        case (cond)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    // dp_arith: full NZCV update; dp_logic: NZ only; neither means no flag update
    logic [1:0] dp_alu;
    logic       dp_wb, dp_arith, dp_logic;

    always_comb begin
        dp_alu   = 2'b00;
        dp_wb    = 1'b0;
        dp_arith = 1'b0;
        dp_logic = 1'b0;
        case (funct[4:1])
            4'b0100: begin dp_alu = 2'b00; dp_wb = 1'b1; dp_arith = 1'b1; end
            4'b0010: begin dp_alu = 2'b01; dp_wb = 1'b1; dp_arith = 1'b1; end
            4'b0000: begin dp_alu = 2'b10; dp_wb = 1'b1; dp_logic = 1'b1; end
            4'b1100: begin dp_alu = 2'b11; dp_wb = 1'b1; dp_logic = 1'b1; end
            4'b1010: begin dp_alu = 2'b01; dp_arith = 1'b1; end
            default: ;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= S_FETCH;
            cond_ex_q <= 1'b0;
            flags     <= 4'b0000;
        end else begin
            state <= state_next;
            if (state == S_DECODE)
                cond_ex_q <= cond_ex;
            if ((state == S_EXECR || state == S_EXECI) && funct[0] && cond_ex_q) begin
                if (dp_arith)
                    flags <= alu_flags;
                else if (dp_logic)
                    flags[3:2] <= alu_flags[3:2];
            end
        end
    end

    logic pc_write_s, ir_write_s, mem_write_s, reg_write_s;
    logic wb_pc, wb_reg;

    assign wb_pc  = cond_ex_q & (rd == 4'd15);
    assign wb_reg = cond_ex_q & (rd != 4'd15);

    always_comb begin
        state_next  = S_FETCH;
        pc_write_s  = 1'b0;
        ir_write_s  = 1'b0;
        mem_write_s = 1'b0;
        reg_write_s = 1'b0;
        adr_src     = 1'b0;
        alu_src_a   = 1'b0;
        alu_src_b   = 2'b00;
        result_src  = 2'b00;
        alu_control = 2'b00;
        case (state)
            S_FETCH: begin
                state_next = S_DECODE;
                ir_write_s = 1'b1;
                pc_write_s = 1'b1;
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
            end
            S_DECODE: begin
                alu_src_a  = 1'b1;
                alu_src_b  = 2'b10;
                result_src = 2'b10;
                case (op)
                    2'b01:   state_next = S_MEMADR;
                    2'b00:   state_next = funct[5] ? S_EXECI : S_EXECR;
                    2'b10:   state_next = S_BRANCH;
                    default: state_next = S_FETCH;
                endcase
            end
            S_MEMADR: begin
                state_next = funct[0] ? S_MEMRD : S_MEMWR;
                alu_src_b  = 2'b01;
            end
            S_MEMRD: begin
                state_next = S_MEMWB;
                adr_src    = 1'b1;
            end
            S_MEMWB: begin
                result_src  = 2'b01;
                reg_write_s = wb_reg;
                pc_write_s  = wb_pc;
            end
            S_MEMWR: begin
                adr_src     = 1'b1;
                mem_write_s = cond_ex_q;
            end
            S_EXECR: begin
                state_next  = S_ALUWB;
                alu_control = dp_alu;
            end
            S_EXECI: begin
                state_next  = S_ALUWB;
                alu_src_b   = 2'b01;
                alu_control = dp_alu;
            end
            S_ALUWB: begin
                reg_write_s = dp_wb & wb_reg;
                pc_write_s  = dp_wb & wb_pc;
            end
            S_BRANCH: begin
                alu_src_b  = 2'b01;
                result_src = 2'b10;
                pc_write_s = cond_ex_q;
            end
            default: state_next = S_FETCH;
        endcase
    end

    // Strobes drop combinationally with reset so no partial write survives the reset cycle
    assign pc_write  = pc_write_s  & ~reset;
    assign ir_write  = ir_write_s  & ~reset;
    assign mem_write = mem_write_s & ~reset;
    assign reg_write = reg_write_s & ~reset;
    assign imm_src   = op;

endmodule

// File: tb/tb_multicycle_controller.sv
// Scoreboard bench for multicycle_controller: directed instructions push per-cycle expected
// control vectors; a monitor pops and compares one vector each falling edge.
module tb_multicycle_controller;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instr;
    logic [3:0]  alu_flags;
    logic        pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a;
    logic [1:0]  alu_src_b, result_src, alu_control, imm_src;
    logic [3:0]  flags;

    multicycle_controller dut (
        .clk(clk), .reset(reset), .instr(instr), .alu_flags(alu_flags),
        .pc_write(pc_write), .ir_write(ir_write), .mem_write(mem_write),
        .reg_write(reg_write), .adr_src(adr_src), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .result_src(result_src), .alu_control(alu_control),
        .imm_src(imm_src), .flags(flags)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [17:0] v;
        int          tag;
    } exp_t;

    exp_t sb[$];
    int   n_checks = 0;
    int   n_fail   = 0;
    event sample_now;
    bit   done = 1'b0;

    logic [17:0] obs;
    assign obs = {pc_write, ir_write, mem_write, reg_write, adr_src, alu_src_a,
                  alu_src_b, result_src, alu_control, imm_src, flags};

    // vector order: pc ir mw rw adr a | b rs ac imm | nzcv
    always @(negedge clk or sample_now) begin
        if (sb.size() != 0) begin
            exp_t e;
            e = sb.pop_front();
            n_checks++;
            if (obs !== e.v) begin
                n_fail++;
                $display("FAIL step%0d: got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b", e.tag,
                         obs[17:12], obs[11:10], obs[9:8], obs[7:4], obs[3:0],
                         e.v[17:12], e.v[11:10], e.v[9:8], e.v[7:4], e.v[3:0]);
            end
        end
    end

    task automatic check_val(input string name, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, got, want);
        end
    endtask

    initial begin
        #100000;
        if (!done) begin
            n_checks++;
            n_fail++;
            $display("FAIL timeout: stimulus did not complete");
            $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
            $finish;
        end
    end

    task automatic push(input int tag, input logic [5:0] strb, input logic [1:0] b,
                        input logic [1:0] rs, input logic [1:0] ac, input logic [1:0] imm,
                        input logic [3:0] fl);
        exp_t e;
        e.v   = {strb, b, rs, ac, imm, fl};
        e.tag = tag;
        sb.push_back(e);
    endtask

    task automatic e_fetch(input int t, input logic [1:0] imm, input logic [3:0] fl);
        push(t, 6'b110001, 2'b10, 2'b10, 2'b00, imm, fl);
    endtask
    task automatic e_decode(input int t, input logic [1:0] imm, input logic [3:0] fl);
        push(t, 6'b000001, 2'b10, 2'b10, 2'b00, imm, fl);
    endtask

    task automatic run(input logic [31:0] i, input logic [3:0] af, input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start(input logic [31:0] i, input logic [3:0] af);
        instr     = i;
        alu_flags = af;
    endtask

    initial begin
        reset     = 1'b1;
        instr     = 32'hE0810002;
        alu_flags = 4'b0000;
        #2;
        check_val("reset strobes", {28'd0, pc_write, ir_write, mem_write, reg_write}, 32'd0);
        check_val("reset flags", {28'd0, flags}, 32'd0);
        push(1, 6'b000001, 2'b10, 2'b10, 2'b00, 2'b00, 4'b0000);
        -> sample_now;
        @(posedge clk);
        #1;
        reset = 1'b0;

        // ADD AL r0,r1,r2: S=0 so alu_flags are ignored
        start(32'hE0810002, 4'b1111);
        e_fetch(10, 2'b00, 4'b0000);
        e_decode(11, 2'b00, 4'b0000);
        push(12, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
        push(13, 6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
        run(instr, alu_flags, 4);

        // SUBS r1,r1,#1 -> Z set
        start(32'hE2511001, 4'b0100);
        e_fetch(20, 2'b00, 4'b0000);
        e_decode(21, 2'b00, 4'b0000);
        push(22, 6'b000000, 2'b01, 2'b00, 2'b01, 2'b00, 4'b0000);
        push(23, 6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0100);
        run(instr, alu_flags, 4);

        // BEQ taken
        start(32'h0A000002, 4'b1111);
        e_fetch(30, 2'b10, 4'b0100);
        e_decode(31, 2'b10, 4'b0100);
        push(32, 6'b100000, 2'b01, 2'b10, 2'b00, 2'b10, 4'b0100);
        run(instr, alu_flags, 3);

        // BNE not taken
        start(32'h1A000002, 4'b1111);
        e_fetch(40, 2'b10, 4'b0100);
        e_decode(41, 2'b10, 4'b0100);
        push(42, 6'b000000, 2'b01, 2'b10, 2'b00, 2'b10, 4'b0100);
        run(instr, alu_flags, 3);

        // LDR r0,[r1,#4]
        start(32'hE5910004, 4'b0000);
        e_fetch(50, 2'b01, 4'b0100);
        e_decode(51, 2'b01, 4'b0100);
        push(52, 6'b000000, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0100);
        push(53, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0100);
        push(54, 6'b000100, 2'b00, 2'b01, 2'b00, 2'b01, 4'b0100);
        run(instr, alu_flags, 5);

        // STR r0,[r1,#4]
        start(32'hE5810004, 4'b0000);
        e_fetch(60, 2'b01, 4'b0100);
        e_decode(61, 2'b01, 4'b0100);
        push(62, 6'b000000, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0100);
        push(63, 6'b001010, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0100);
        run(instr, alu_flags, 4);

        // LDR pc,[r1,#4]
        start(32'hE591F004, 4'b0000);
        e_fetch(70, 2'b01, 4'b0100);
        e_decode(71, 2'b01, 4'b0100);
        push(72, 6'b000000, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0100);
        push(73, 6'b000010, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0100);
        push(74, 6'b100000, 2'b00, 2'b01, 2'b00, 2'b01, 4'b0100);
        run(instr, alu_flags, 5);

        // CMP r1,r2: flags update, no writeback
        start(32'hE1510002, 4'b1000);
        e_fetch(80, 2'b00, 4'b0100);
        e_decode(81, 2'b00, 4'b0100);
        push(82, 6'b000000, 2'b00, 2'b00, 2'b01, 2'b00, 4'b0100);
        push(83, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1000);
        run(instr, alu_flags, 4);

        // ADDS -> flags 0111
        start(32'hE0910002, 4'b0111);
        e_fetch(90, 2'b00, 4'b1000);
        e_decode(91, 2'b00, 4'b1000);
        push(92, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1000);
        push(93, 6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111);
        run(instr, alu_flags, 4);

        // ANDS alu=1011 from flags 0111 -> 1011
        start(32'hE0110002, 4'b1011);
        e_fetch(100, 2'b00, 4'b0111);
        e_decode(101, 2'b00, 4'b0111);
        push(102, 6'b000000, 2'b00, 2'b00, 2'b10, 2'b00, 4'b0111);
        push(103, 6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b1011);
        run(instr, alu_flags, 4);

        // ORRS alu=0100 from flags 1011 -> NZ=01, CV=11 held
        start(32'hE1910002, 4'b0100);
        e_fetch(110, 2'b00, 4'b1011);
        e_decode(111, 2'b00, 4'b1011);
        push(112, 6'b000000, 2'b00, 2'b00, 2'b11, 2'b00, 4'b1011);
        push(113, 6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111);
        run(instr, alu_flags, 4);

        // EORS (unsupported): ADD op, no writeback, no flag update
        start(32'hE0310002, 4'b1111);
        e_fetch(120, 2'b00, 4'b0111);
        e_decode(121, 2'b00, 4'b0111);
        push(122, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111);
        push(123, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111);
        run(instr, alu_flags, 4);

        // ADDSNE with Z=1: condition false, no write, no flag update
        start(32'h10910002, 4'b1111);
        e_fetch(130, 2'b00, 4'b0111);
        e_decode(131, 2'b00, 4'b0111);
        push(132, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111);
        push(133, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0111);
        run(instr, alu_flags, 4);

        // undefined op=11: 2 cycles
        start(32'hEC000000, 4'b1111);
        e_fetch(140, 2'b11, 4'b0111);
        e_decode(141, 2'b11, 4'b0111);
        run(instr, alu_flags, 2);

        // STR with reset asserted during MEMWR
        start(32'hE5810004, 4'b0000);
        e_fetch(150, 2'b01, 4'b0111);
        e_decode(151, 2'b01, 4'b0111);
        push(152, 6'b000000, 2'b01, 2'b00, 2'b00, 2'b01, 4'b0111);
        push(153, 6'b001010, 2'b00, 2'b00, 2'b00, 2'b01, 4'b0111);
        repeat (3) @(posedge clk);
        @(negedge clk);
        #2;
        reset = 1'b1;
        #1;
        check_val("mid-reset mem_write", {31'd0, mem_write}, 32'd0);
        check_val("mid-reset flags", {28'd0, flags}, 32'd0);
        push(154, 6'b000001, 2'b10, 2'b10, 2'b00, 2'b01, 4'b0000);
        -> sample_now;
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b0;

        // first instruction after release starts in FETCH
        start(32'hE0810002, 4'b0000);
        e_fetch(160, 2'b00, 4'b0000);
        e_decode(161, 2'b00, 4'b0000);
        push(162, 6'b000000, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
        push(163, 6'b000100, 2'b00, 2'b00, 2'b00, 2'b00, 4'b0000);
        run(instr, alu_flags, 4);

        @(negedge clk);
        #1;
        check_val("scoreboard drained", sb.size(), 32'd0);
        done = 1'b1;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
